// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package serial_adder_pkg;

  // Default operand/result width in bits.
  localparam int unsigned DefaultWidth = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder built from XOR/AND/OR gates.
// This is the single shared cell that the serial controller sequences.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign sum     = a_xor_b ^ c;
  assign carry   = (a & b) | (c & a_xor_b);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine. Latches operands on start, feeds one bit per
// clock (LSB first) through a shared full-adder cell with a registered carry,
// then presents result, carry-out and signed overflow with a one-cycle done.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sb_q, result_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             msb_cin_q;

  logic cell_sum, cell_carry;
  logic last_bit;

  full_adder_cell u_cell (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .c     (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign last_bit = (cnt_q == LastBit);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (last_bit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and held datapath registers.
  always_comb begin
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    result = result_q;
    cout   = cout_q;
    ovf    = msb_cin_q ^ cout_q;
  end

  // Datapath: operand shift registers, carry, bit counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q      <= '0;
      sb_q      <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      msb_cin_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q    <= op_a;
            // Subtraction is A + ~B + 1; external cin is ignored.
            sb_q    <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          result_q <= {cell_sum, result_q[WIDTH-1:1]};
          sa_q     <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q     <= {1'b0, sb_q[WIDTH-1:1]};
          carry_q  <= cell_carry;
          if (last_bit) begin
            msb_cin_q <= carry_q;
            cout_q    <= cell_carry;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .cin    (cin),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned for result/carry, signed for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic c,
                                output logic [W-1:0] r, output logic co, output logic ov);
    int ua, ub, ssa, ssb, ur, sr;
    ua  = int'(a);
    ub  = int'(b);
    ssa = int'($signed(a));
    ssb = int'($signed(b));
    if (s) begin
      ur = ua - ub;
      sr = ssa - ssb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(c);
      sr = ssa + ssb + int'(c);
      co = (ur > 255);
    end
    r  = 8'(ur);
    ov = (sr > 127) || (sr < -128);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input string name);
    logic [W-1:0] er;
    logic         ec, eo;
    int           n, busy_cnt;
    model(a, b, s, c, er, ec, eo);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    // Scramble inputs during RUN; they must not affect the result.
    start = 1'b0;
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
    sub   = 1'($urandom);
    cin   = 1'($urandom);
    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== W) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, n, W);
    end
    checks++;
    if (busy_cnt !== W) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, W);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_done_overlap: got busy=%b expected 0", name, busy);
    end
    checks++;
    if (result !== er) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, result, er);
    end
    checks++;
    if (cout !== ec) begin
      failures++;
      $display("FAIL %s cout: got %b expected %b", name, cout, ec);
    end
    checks++;
    if (ovf !== eo) begin
      failures++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, eo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cout, ovf} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, cout, ovf});
    end
    checks++;
    if (result !== '0) begin
      failures++;
      $display("FAIL reset_result: got %h expected 00", result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, "add_5a_33");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "wrap_ff_01");
    run_op(8'hFF, 8'h00, 1'b0, 1'b1, "wrap_ff_00_cin");
    run_op(8'h10, 8'h20, 1'b1, 1'b0, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, 1'b1, "sub_80_01");
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf_pos");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  // start held high: an op is accepted every W+2 cycles using the operands seen at that edge.
  task automatic test_back_to_back();
    logic [W-1:0] ha [0:40];
    logic [W-1:0] hb [0:40];
    logic         hs [0:40];
    logic         hc [0:40];
    logic [W-1:0] er;
    logic         ec, eo, exp_done, exp_busy;
    ha[0] = 8'($urandom); hb[0] = 8'($urandom); hs[0] = 1'($urandom); hc[0] = 1'($urandom);
    op_a = ha[0]; op_b = hb[0]; sub = hs[0]; cin = hc[0]; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_done = ((i % (W + 2)) == W);
      exp_busy = ((i % (W + 2)) < W);
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        failures++;
        $display("FAIL b2b_handshake cycle %0d: got done=%b busy=%b expected %b %b",
                 i, done, busy, exp_done, exp_busy);
      end
      if (exp_done) begin
        model(ha[i-W], hb[i-W], hs[i-W], hc[i-W], er, ec, eo);
        checks++;
        if ({result, cout, ovf} !== {er, ec, eo}) begin
          failures++;
          $display("FAIL b2b_result cycle %0d: got %h/%b/%b expected %h/%b/%b",
                   i, result, cout, ovf, er, ec, eo);
        end
      end
      ha[i+1] = 8'($urandom); hb[i+1] = 8'($urandom);
      hs[i+1] = 1'($urandom); hc[i+1] = 1'($urandom);
      op_a = ha[i+1]; op_b = hb[i+1]; sub = hs[i+1]; cin = hc[i+1];
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op_a = 8'hC3; op_b = 8'h5A; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, cout, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_mid_op_async: got busy=%b done=%b result=%h cout=%b ovf=%b expected 0",
               busy, done, result, cout, ovf);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_op_no_done cycle %0d: got done=%b busy=%b expected 0 0",
                 i, done, busy);
      end
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, "post_reset_add");
  endtask

  task automatic test_hold();
    logic [W-1:0] er;
    logic         ec, eo;
    model(8'h80, 8'h01, 1'b1, 1'b0, er, ec, eo);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, "hold_setup");
    for (int i = 0; i < 20; i++) begin
      op_a = 8'($urandom); op_b = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({result, cout, ovf} !== {er, ec, eo} || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle %0d: got %h/%b/%b busy=%b done=%b expected %h/%b/%b 0 0",
                 i, result, cout, ovf, busy, done, er, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
